// File: rtl/lap_record_ctrl_pkg.sv
// Shared types and constants for the lap-record stopwatch controller.
// Holds the main FSM state codes, the read-sequencer codes and the key
// indices used to address the synchronised key-edge vector.
package lap_record_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        STOPPED = 2'd3
    } sw_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2
    } rd_state_t;

    localparam int KEY_START  = 0;
    localparam int KEY_RECORD = 1;
    localparam int KEY_PAUSE  = 2;
    localparam int KEY_LOAD   = 3;
    localparam int NUM_KEYS   = 4;

endpackage

// File: rtl/lap_record_ctrl_if.sv
// Single-port lap RAM bus. The controller is the master (address, write
// enable, write data); the RAM is the slave and returns read data.
interface lap_record_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              wren;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_ram;

    modport master (output address, output wren, output data_write, input data_ram);
    modport slave  (input address, input wren, input data_write, output data_ram);
endinterface

// File: rtl/lap_record_ctrl_key_edge_sync.sv
// Key conditioner: two-flop synchroniser followed by a registered
// rising-edge detector. A key sampled high at edge k yields a one-cycle
// pulse visible between edges k+2 and k+3.
module key_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic pulse_o
);
    logic sync1_q, sync2_q, prev_q, pulse_q;

    // Synchronise the level, remember its previous value, register the rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/lap_record_ctrl.sv
// Stopwatch controller with a circular lap memory in an external RAM.
// Keys are synchronised and edge-detected, a START/RUN/PAUSE/STOPPED FSM
// drives the counter controls, laps are written while running and recalled
// newest-first while stopped.
// Build option: define LAP_OVERWRITE_EN to let a record on a full buffer
// overwrite the oldest lap; otherwise such a record is dropped.
module lap_record_ctrl
    import lap_record_ctrl_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start_i,
    input  logic              key_record_i,
    input  logic              key_pause_i,
    input  logic              key_load_i,
    input  logic [DATA_W-1:0] watch_data_i,
    lap_record_ctrl_if.master ram,
    output logic              cnt_rst_o,
    output logic              cnt_en_o,
    output logic              cnt_load_o,
    output logic [DATA_W-1:0] disp_out_o,
    output logic [ADDR_W:0]   lap_count_o,
    output logic              recall_mode_o
);
`ifdef LAP_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    logic [NUM_KEYS-1:0] key_raw, key_edge;
    sw_state_t           state_q;
    rd_state_t           rd_state_q;
    logic [1:0]          lat_cnt_q;
    logic                cnt_rst_q, cnt_en_q, cnt_load_q, wren_q;
    logic [ADDR_W-1:0]   address_q, wr_ptr_q, rd_idx_q;
    logic [DATA_W-1:0]   data_write_q, data_read_q;
    logic [ADDR_W:0]     lap_count_q;
    logic                recall_active_q, recall_mode_q;
    logic                lap_full;
    logic [ADDR_W-1:0]   oldest_idx, newest_idx, rd_next;

    assign key_raw = {key_load_i, key_pause_i, key_record_i, key_start_i};

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_edge_sync u_sync (
                .clk     (clk),
                .rst     (rst),
                .key_i   (key_raw[gi]),
                .pulse_o (key_edge[gi])
            );
        end
    endgenerate

    // lap_count never exceeds DEPTH, so its MSB alone flags a full buffer;
    // when full the low bits are zero and oldest_idx collapses to wr_ptr.
    assign lap_full   = lap_count_q[ADDR_W];
    assign oldest_idx = wr_ptr_q - lap_count_q[ADDR_W-1:0];
    assign newest_idx = wr_ptr_q - ADDR_W'(1);
    assign rd_next    = (!recall_active_q || (rd_idx_q == oldest_idx)) ? newest_idx
                                                                       : rd_idx_q - ADDR_W'(1);

    // Main FSM with lap write, recall issue and read-latency sequencing.
    // The read sequencer is updated first so a start edge can abort it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rd_state_q      <= RD_IDLE;
            lat_cnt_q       <= '0;
            cnt_rst_q       <= 1'b1;
            cnt_en_q        <= 1'b0;
            cnt_load_q      <= 1'b0;
            wren_q          <= 1'b0;
            address_q       <= '0;
            data_write_q    <= '0;
            data_read_q     <= '0;
            wr_ptr_q        <= '0;
            rd_idx_q        <= '0;
            lap_count_q     <= '0;
            recall_active_q <= 1'b0;
            recall_mode_q   <= 1'b0;
        end else begin
            wren_q     <= 1'b0;
            cnt_load_q <= key_edge[KEY_LOAD] && (state_q == IDLE);

            case (rd_state_q)
                RD_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) rd_state_q <= RD_CAP;
                    else                       lat_cnt_q  <= lat_cnt_q + 2'd1;
                end
                RD_CAP: begin
                    data_read_q   <= ram.data_ram;
                    recall_mode_q <= 1'b1;
                    rd_state_q    <= RD_IDLE;
                end
                default: ;
            endcase

            if (key_edge[KEY_START]) begin
                case (state_q)
                    IDLE: begin
                        state_q   <= RUN;
                        cnt_rst_q <= 1'b0;
                        cnt_en_q  <= 1'b1;
                    end
                    RUN, PAUSE: begin
                        state_q  <= STOPPED;
                        cnt_en_q <= 1'b0;
                    end
                    STOPPED: begin
                        state_q         <= IDLE;
                        cnt_rst_q       <= 1'b1;
                        lap_count_q     <= '0;
                        wr_ptr_q        <= '0;
                        recall_active_q <= 1'b0;
                        recall_mode_q   <= 1'b0;
                        rd_state_q      <= RD_IDLE;
                    end
                endcase
            end else if (key_edge[KEY_PAUSE]) begin
                if (state_q == RUN) begin
                    state_q  <= PAUSE;
                    cnt_en_q <= 1'b0;
                end else if (state_q == PAUSE) begin
                    state_q  <= RUN;
                    cnt_en_q <= 1'b1;
                end
            end else if (key_edge[KEY_RECORD]) begin
                if ((state_q == RUN) || (state_q == PAUSE)) begin
                    if (!lap_full || OVERWRITE) begin
                        wren_q       <= 1'b1;
                        address_q    <= wr_ptr_q;
                        data_write_q <= watch_data_i;
                        wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
                        if (!lap_full) lap_count_q <= lap_count_q + (ADDR_W+1)'(1);
                    end
                end else if ((state_q == STOPPED) && (lap_count_q != '0) &&
                             (rd_state_q == RD_IDLE)) begin
                    address_q       <= rd_next;
                    rd_idx_q        <= rd_next;
                    recall_active_q <= 1'b1;
                    lat_cnt_q       <= '0;
                    rd_state_q      <= RD_WAIT;
                end
            end
        end
    end

    assign ram.address    = address_q;
    assign ram.wren       = wren_q;
    assign ram.data_write = data_write_q;
    assign cnt_rst_o      = cnt_rst_q;
    assign cnt_en_o       = cnt_en_q;
    assign cnt_load_o     = cnt_load_q;
    assign lap_count_o    = lap_count_q;
    assign recall_mode_o  = recall_mode_q;
    assign disp_out_o     = recall_mode_q ? data_read_q : watch_data_i;
endmodule

// File: tb/tb_lap_record_ctrl.sv
// Self-checking bench for lap_record_ctrl (DEPTH=4, RD_LAT=3) with a
// behavioural RAM and a lap-queue reference model.
module tb_lap_record_ctrl;
    localparam int DW = 24, AW = 2, DEPTH = 4, RDL = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_STOP = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic key_start = 1'b0, key_record = 1'b0, key_pause = 1'b0, key_load = 1'b0;
    logic [DW-1:0] watch_data = '0;
    logic cnt_rst, cnt_en, cnt_load, recall_mode;
    logic [DW-1:0] disp_out;
    logic [AW:0]   lap_count;

    lap_record_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

    lap_record_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RDL)) dut (
        .clk(clk), .rst(rst),
        .key_start_i(key_start), .key_record_i(key_record),
        .key_pause_i(key_pause), .key_load_i(key_load),
        .watch_data_i(watch_data), .ram(ram_if),
        .cnt_rst_o(cnt_rst), .cnt_en_o(cnt_en), .cnt_load_o(cnt_load),
        .disp_out_o(disp_out), .lap_count_o(lap_count), .recall_mode_o(recall_mode)
    );

    always #5 clk = ~clk;

    // RAM with RDL cycles of read latency
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] pipe [RDL];
    always @(posedge clk) begin
        if (ram_if.wren === 1'b1) mem[ram_if.address] <= ram_if.data_write;
        pipe[0] <= mem[ram_if.address];
        for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_if.data_ram = pipe[RDL-1];

    // Monitor of write pulses and load pulses
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int obs_loads = 0;
    always @(negedge clk) begin
        if (ram_if.wren === 1'b1) begin
            obs_addr.push_back(ram_if.address);
            obs_data.push_back(ram_if.data_write);
        end
        if (cnt_load === 1'b1) obs_loads++;
    end

    // Reference model
    int m_state = S_IDLE;
    logic [DW-1:0] laps[$];
    int m_wr_ptr = 0, m_pos = -1, exp_loads = 0, n_wchk = 0;
    bit m_recall = 1'b0;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cnt_rst"}, 32'(cnt_rst), 32'd1);
        chk({tag, "_cnt_en"}, 32'(cnt_en), 32'd0);
        chk({tag, "_cnt_load"}, 32'(cnt_load), 32'd0);
        chk({tag, "_wren"}, 32'(ram_if.wren), 32'd0);
        chk({tag, "_address"}, 32'(ram_if.address), 32'd0);
        chk({tag, "_data_write"}, 32'(ram_if.data_write), 32'd0);
        chk({tag, "_lap_count"}, 32'(lap_count), 32'd0);
        chk({tag, "_recall_mode"}, 32'(recall_mode), 32'd0);
        chk({tag, "_disp_out"}, 32'(disp_out), 32'(watch_data));
    endtask

    task automatic check_all();
        logic [DW-1:0] exp_disp;
        exp_disp = m_recall ? laps[laps.size() - 1 - m_pos] : watch_data;
        chk("cnt_en", 32'(cnt_en), 32'(m_state == S_RUN));
        chk("cnt_rst", 32'(cnt_rst), 32'(m_state == S_IDLE));
        chk("lap_count", 32'(lap_count), 32'(laps.size()));
        chk("recall_mode", 32'(recall_mode), 32'(m_recall));
        chk("disp_out", 32'(disp_out), 32'(exp_disp));
        chk("write_count", 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = n_wchk; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk("write_addr", 32'(obs_addr[i]), 32'(exp_addr[i]));
            chk("write_data", 32'(obs_data[i]), 32'(exp_data[i]));
        end
        n_wchk = exp_addr.size();
        chk("load_pulses", 32'(obs_loads), 32'(exp_loads));
    endtask

    task automatic model_write(input logic [DW-1:0] wd);
        exp_addr.push_back(AW'(m_wr_ptr));
        exp_data.push_back(wd);
        m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
    endtask

    task automatic model_clear();
        m_state = S_IDLE;
        laps.delete();
        m_wr_ptr = 0;
        m_pos = -1;
        m_recall = 1'b0;
    endtask

    task automatic press(input bit s, input bit r, input bit p, input bit l, input logic [DW-1:0] wd);
        int st0;
        st0 = m_state;
        @(negedge clk);
        watch_data = wd;
        key_start = s; key_record = r; key_pause = p; key_load = l;
        repeat (2) @(negedge clk);
        key_start = 1'b0; key_record = 1'b0; key_pause = 1'b0; key_load = 1'b0;
        repeat (12) @(negedge clk);
        if (s) begin
            if (st0 == S_IDLE) m_state = S_RUN;
            else if (st0 == S_STOP) model_clear();
            else m_state = S_STOP;
        end else if (p) begin
            if (st0 == S_RUN) m_state = S_PAUSE;
            else if (st0 == S_PAUSE) m_state = S_RUN;
        end else if (r) begin
            if (st0 == S_RUN || st0 == S_PAUSE) begin
                if (laps.size() < DEPTH) begin
                    model_write(wd);
                    laps.push_back(wd);
                end
`ifdef LAP_OVERWRITE_EN
                else begin
                    model_write(wd);
                    void'(laps.pop_front());
                    laps.push_back(wd);
                end
`endif
            end else if (st0 == S_STOP && laps.size() > 0) begin
                m_pos = (m_pos + 1) % laps.size();
                m_recall = 1'b1;
            end
        end
        if (l && st0 == S_IDLE) exp_loads++;
        $display("[TB] keys s%0d r%0d p%0d l%0d wd=%06h -> state %0d laps %0d disp %06h",
                 s, r, p, l, wd, m_state, laps.size(), disp_out);
        check_all();
    endtask

    initial begin
        // 1: reset
        repeat (3) @(negedge clk);
        chk_reset("in_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("after_reset");
        check_all();

        // 2: three laps while running
        press(1, 0, 0, 0, 24'h000100);
        press(0, 1, 0, 0, 24'h000105);
        press(0, 1, 0, 0, 24'h000210);
        press(0, 1, 0, 0, 24'h000315);

        // 3: stop and recall four times (wraps to newest)
        press(1, 0, 0, 0, 24'h000400);
        repeat (4) press(0, 1, 0, 0, 24'h000401);

        // 4: five records into a four-deep buffer, then recall
        press(1, 0, 0, 0, 24'h000500);
        press(0, 0, 0, 1, 24'h000501);
        press(1, 0, 0, 0, 24'h000502);
        for (int i = 0; i < 5; i++) press(0, 1, 0, 0, 24'h001000 + 24'(i * 17));
        press(1, 0, 0, 0, 24'h000600);
        press(0, 1, 0, 0, 24'h000601);

        // 5: pause handling and start/record collision
        press(1, 0, 0, 0, 24'h000700);
        press(0, 0, 1, 0, 24'h000701);
        press(1, 0, 0, 0, 24'h000702);
        press(0, 0, 1, 0, 24'h000703);
        press(0, 0, 1, 0, 24'h000704);
        press(0, 1, 0, 0, 24'h000705);
        press(1, 1, 0, 0, 24'h000706);
        press(0, 0, 1, 0, 24'h000707);

        // 6: reset while a recall read is waiting on RAM latency
        @(negedge clk);
        key_record = 1'b1;
        repeat (2) @(negedge clk);
        key_record = 1'b0;
        repeat (3) @(negedge clk);
        chk("rd_issue_addr", 32'(ram_if.address), 32'((m_wr_ptr + DEPTH - 1) % DEPTH));
        chk("rd_wait_recall", 32'(recall_mode), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset("mid_read_reset");
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_reset_recall", 32'(recall_mode), 32'd0);
        check_all();

        // Randomised key sequences against the model
        for (int n = 0; n < 80; n++) begin
            int sel;
            logic [3:0] mask;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:       mask = 4'b0001;
                2, 3:       mask = 4'b0100;
                4, 5, 6, 7: mask = 4'b0010;
                8:          mask = 4'b1000;
                default:    mask = 4'($urandom_range(1, 15));
            endcase
            press(mask[0], mask[1], mask[2], mask[3], 24'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
